// File: rtl/reg_file_pkg.sv
// Shared widths and id conventions for the architectural register file.
// ROB id 0 and register 0 both mean "none"; neither is ever stored.
package reg_file_pkg;

  localparam int XLEN_DEFAULT         = 32;
  localparam int REG_ID_WIDTH_DEFAULT = 5;
  localparam int ROB_ID_WIDTH_DEFAULT = 4;

  typedef logic [XLEN_DEFAULT-1:0]         reg_t;
  typedef logic [REG_ID_WIDTH_DEFAULT-1:0] reg_id_t;
  typedef logic [ROB_ID_WIDTH_DEFAULT-1:0] rob_id_t;

  localparam rob_id_t ROB_ID_NONE = '0;
  localparam reg_id_t REG_ZERO    = '0;

  typedef struct packed {
    reg_t    value;
    rob_id_t tag;
  } operand_t;

endpackage

// File: rtl/reg_file_read_port.sv
// Combinational source-operand read: x0 forcing plus optional commit bypass.
// Latency 0; no state, so rdy has no effect here.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int REG_ID_WIDTH = REG_ID_WIDTH_DEFAULT,
  parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEFAULT,
  parameter bit BYPASS_EN    = 1'b0
) (
  input  logic [REG_ID_WIDTH-1:0] rs,
  input  logic [XLEN-1:0]         stored_value,
  input  logic [ROB_ID_WIDTH-1:0] stored_tag,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
  input  logic [XLEN-1:0]         value_from_rob,
  output logic [XLEN-1:0]         value,
  output logic [ROB_ID_WIDTH-1:0] tag
);

  logic bypass_hit;

  // Only forward when the committing id is the one this register waits on;
  // a younger writer's tag must stay visible.
  assign bypass_hit = BYPASS_EN
                   && (rs != '0)
                   && (rs == rd_from_rob)
                   && (dest_from_rob != '0)
                   && (stored_tag == dest_from_rob);

  always_comb begin
    value = stored_value;
    tag   = stored_tag;
    if (rs == '0) begin
      value = '0;
      tag   = '0;
    end else if (bypass_hit) begin
      value = value_from_rob;
      tag   = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Renamed architectural register file; optional commit bypass via REG_FILE_COMMIT_BYPASS_EN.
// Reads are 0-cycle; rename/commit/flush land on the next edge and all state holds while rdy is low.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int REG_ID_WIDTH = REG_ID_WIDTH_DEFAULT,
  parameter int ROB_ID_WIDTH = ROB_ID_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    reset_from_rob_bus,
  input  logic [REG_ID_WIDTH-1:0] rs1_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rs2_from_issuer,
  output logic [XLEN-1:0]         value_of_rs1_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] tag_of_rs1_to_issuer,
  output logic [XLEN-1:0]         value_of_rs2_to_issuer,
  output logic [ROB_ID_WIDTH-1:0] tag_of_rs2_to_issuer,
  input  logic                    valid_from_issuer,
  input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
  input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
  input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
  input  logic [XLEN-1:0]         value_from_rob
);

  localparam int NUM_REGS = 1 << REG_ID_WIDTH;

`ifdef REG_FILE_COMMIT_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [XLEN-1:0]         value_q [1:NUM_REGS-1];
  logic [ROB_ID_WIDTH-1:0] tag_q   [1:NUM_REGS-1];

  logic commit_en;
  logic rename_en;
  logic flush_en;

  logic [XLEN-1:0]         rs1_stored_value;
  logic [ROB_ID_WIDTH-1:0] rs1_stored_tag;
  logic [XLEN-1:0]         rs2_stored_value;
  logic [ROB_ID_WIDTH-1:0] rs2_stored_tag;

  assign commit_en = rdy && (dest_from_rob != '0) && (rd_from_rob != '0);
  assign flush_en  = rdy && reset_from_rob_bus;
  assign rename_en = rdy && valid_from_issuer && (rd_from_issuer != '0) && !reset_from_rob_bus;

  // x0 has no storage entry, so the lookup defaults to zero for it.
  always_comb begin
    rs1_stored_value = '0;
    rs1_stored_tag   = '0;
    rs2_stored_value = '0;
    rs2_stored_tag   = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs1_from_issuer == REG_ID_WIDTH'(i)) begin
        rs1_stored_value = value_q[i];
        rs1_stored_tag   = tag_q[i];
      end
      if (rs2_from_issuer == REG_ID_WIDTH'(i)) begin
        rs2_stored_value = value_q[i];
        rs2_stored_tag   = tag_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (commit_en && (rd_from_rob == REG_ID_WIDTH'(i))) begin
          value_q[i] <= value_from_rob;
        end
        // Priority: flush clears everything, then a new rename beats the
        // commit's tag release since the new writer is younger.
        if (flush_en) begin
          tag_q[i] <= '0;
        end else if (rename_en && (rd_from_issuer == REG_ID_WIDTH'(i))) begin
          tag_q[i] <= dest_from_issuer;
        end else if (commit_en && (rd_from_rob == REG_ID_WIDTH'(i))
                     && (tag_q[i] == dest_from_rob)) begin
          tag_q[i] <= '0;
        end
      end
    end
  end

  reg_file_read_port #(
    .XLEN         (XLEN),
    .REG_ID_WIDTH (REG_ID_WIDTH),
    .ROB_ID_WIDTH (ROB_ID_WIDTH),
    .BYPASS_EN    (BYPASS_EN)
  ) u_rs1_port (
    .rs             (rs1_from_issuer),
    .stored_value   (rs1_stored_value),
    .stored_tag     (rs1_stored_tag),
    .dest_from_rob  (dest_from_rob),
    .rd_from_rob    (rd_from_rob),
    .value_from_rob (value_from_rob),
    .value          (value_of_rs1_to_issuer),
    .tag            (tag_of_rs1_to_issuer)
  );

  reg_file_read_port #(
    .XLEN         (XLEN),
    .REG_ID_WIDTH (REG_ID_WIDTH),
    .ROB_ID_WIDTH (ROB_ID_WIDTH),
    .BYPASS_EN    (BYPASS_EN)
  ) u_rs2_port (
    .rs             (rs2_from_issuer),
    .stored_value   (rs2_stored_value),
    .stored_tag     (rs2_stored_tag),
    .dest_from_rob  (dest_from_rob),
    .rd_from_rob    (rd_from_rob),
    .value_from_rob (value_from_rob),
    .value          (value_of_rs2_to_issuer),
    .tag            (tag_of_rs2_to_issuer)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expected values are hand-computed.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        reset_from_rob_bus = 1'b0;
  logic [4:0]  rs1_from_issuer = '0;
  logic [4:0]  rs2_from_issuer = '0;
  logic [31:0] value_of_rs1_to_issuer;
  logic [3:0]  tag_of_rs1_to_issuer;
  logic [31:0] value_of_rs2_to_issuer;
  logic [3:0]  tag_of_rs2_to_issuer;
  logic        valid_from_issuer = 1'b0;
  logic [4:0]  rd_from_issuer = '0;
  logic [3:0]  dest_from_issuer = '0;
  logic [3:0]  dest_from_rob = '0;
  logic [4:0]  rd_from_rob = '0;
  logic [31:0] value_from_rob = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file dut (
    .clk                    (clk),
    .rst                    (rst),
    .rdy                    (rdy),
    .reset_from_rob_bus     (reset_from_rob_bus),
    .rs1_from_issuer        (rs1_from_issuer),
    .rs2_from_issuer        (rs2_from_issuer),
    .value_of_rs1_to_issuer (value_of_rs1_to_issuer),
    .tag_of_rs1_to_issuer   (tag_of_rs1_to_issuer),
    .value_of_rs2_to_issuer (value_of_rs2_to_issuer),
    .tag_of_rs2_to_issuer   (tag_of_rs2_to_issuer),
    .valid_from_issuer      (valid_from_issuer),
    .rd_from_issuer         (rd_from_issuer),
    .dest_from_issuer       (dest_from_issuer),
    .dest_from_rob          (dest_from_rob),
    .rd_from_rob            (rd_from_rob),
    .value_from_rob         (value_from_rob)
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before touching inputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_from_issuer  = 1'b0;
    rd_from_issuer     = '0;
    dest_from_issuer   = '0;
    dest_from_rob      = '0;
    rd_from_rob        = '0;
    value_from_rob     = '0;
    reset_from_rob_bus = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] dest);
    valid_from_issuer = 1'b1;
    rd_from_issuer    = rd;
    dest_from_issuer  = dest;
  endtask

  task automatic commit(input logic [3:0] dest, input logic [4:0] rd, input logic [31:0] val);
    dest_from_rob  = dest;
    rd_from_rob    = rd;
    value_from_rob = val;
  endtask

  initial begin
    // Reset state while rst is low
    rs1_from_issuer = 5'd5;
    rs2_from_issuer = 5'd0;
    #12;
    check("rst_rs1_value", value_of_rs1_to_issuer, 32'h0);
    check("rst_rs1_tag",   {28'h0, tag_of_rs1_to_issuer}, 32'h0);
    check("rst_rs2_value", value_of_rs2_to_issuer, 32'h0);
    check("rst_rs2_tag",   {28'h0, tag_of_rs2_to_issuer}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_rs1_value", value_of_rs1_to_issuer, 32'h0);

    // Rename then commit
    issue(5'd3, 4'd7);
    tick();
    idle();
    rs1_from_issuer = 5'd3;
    #1;
    check("rename_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd7);
    check("rename_value", value_of_rs1_to_issuer, 32'h0);
    commit(4'd7, 5'd3, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("commit_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd0);
    check("commit_value", value_of_rs1_to_issuer, 32'hDEADBEEF);

    // Older commit must not clear a younger writer's tag
    issue(5'd3, 4'd7);
    tick();
    issue(5'd3, 4'd9);
    tick();
    idle();
    commit(4'd7, 5'd3, 32'h11);
    tick();
    idle();
    #1;
    check("stale_commit_value", value_of_rs1_to_issuer, 32'h11);
    check("stale_commit_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd9);

    // Commit and rename the same rd together
    commit(4'd4, 5'd6, 32'h22);
    issue(5'd6, 4'd5);
    tick();
    idle();
    rs2_from_issuer = 5'd6;
    #1;
    check("same_rd_value", value_of_rs2_to_issuer, 32'h22);
    check("same_rd_tag", {28'h0, tag_of_rs2_to_issuer}, 32'd5);

    // rdy low freezes state
    rdy = 1'b0;
    issue(5'd8, 4'd3);
    commit(4'd2, 5'd8, 32'h99);
    tick();
    idle();
    rdy = 1'b1;
    rs1_from_issuer = 5'd8;
    #1;
    check("hold_value", value_of_rs1_to_issuer, 32'h0);
    check("hold_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd0);

    // Flush with concurrent commit and rename
    issue(5'd1, 4'd1);
    tick();
    issue(5'd2, 4'd2);
    tick();
    issue(5'd31, 4'd3);
    tick();
    idle();
    rs1_from_issuer = 5'd31;
    #1;
    check("pre_flush_x31_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd3);
    reset_from_rob_bus = 1'b1;
    commit(4'd1, 5'd1, 32'h33);
    issue(5'd2, 4'd6);
    tick();
    idle();
    rs1_from_issuer = 5'd1;
    rs2_from_issuer = 5'd2;
    #1;
    check("flush_x1_value", value_of_rs1_to_issuer, 32'h33);
    check("flush_x1_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd0);
    check("flush_x2_tag", {28'h0, tag_of_rs2_to_issuer}, 32'd0);
    rs1_from_issuer = 5'd31;
    rs2_from_issuer = 5'd3;
    #1;
    check("flush_x31_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd0);
    check("flush_x3_tag", {28'h0, tag_of_rs2_to_issuer}, 32'd0);
    check("flush_x3_value", value_of_rs2_to_issuer, 32'h11);

    // x0 is never renamed or written
    issue(5'd0, 4'd8);
    commit(4'd8, 5'd0, 32'h44);
    tick();
    idle();
    rs1_from_issuer = 5'd0;
    #1;
    check("x0_value", value_of_rs1_to_issuer, 32'h0);
    check("x0_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd0);

    // Same-cycle read during the matching commit
    issue(5'd3, 4'd7);
    tick();
    idle();
    rs1_from_issuer = 5'd3;
    commit(4'd7, 5'd3, 32'h55);
    #1;
`ifdef REG_FILE_COMMIT_BYPASS_EN
    check("bypass_value", value_of_rs1_to_issuer, 32'h55);
    check("bypass_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd0);
`else
    check("nobypass_value", value_of_rs1_to_issuer, 32'h11);
    check("nobypass_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd7);
`endif
    tick();
    idle();
    #1;
    check("after_commit_value", value_of_rs1_to_issuer, 32'h55);
    check("after_commit_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd0);

    // Asynchronous reset mid-run, away from any clock edge
    issue(5'd3, 4'd2);
    tick();
    idle();
    rs1_from_issuer = 5'd6;
    rs2_from_issuer = 5'd3;
    #1;
    check("pre_arst_x3_tag", {28'h0, tag_of_rs2_to_issuer}, 32'd2);
    #1;
    rst = 1'b0;
    #1;
    check("arst_x6_value", value_of_rs1_to_issuer, 32'h0);
    check("arst_x6_tag", {28'h0, tag_of_rs1_to_issuer}, 32'd0);
    check("arst_x3_value", value_of_rs2_to_issuer, 32'h0);
    check("arst_x3_tag", {28'h0, tag_of_rs2_to_issuer}, 32'd0);
    // Reset dominates a commit presented on the same edge
    commit(4'd5, 5'd6, 32'h77);
    tick();
    idle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_arst_x6_value", value_of_rs1_to_issuer, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
